// File: rtl/shape_draw_scheduler.sv
// shape_draw_scheduler: sequences shape-drawer channels onto one VGA pixel port, clear shape first each frame
module shape_draw_scheduler #(
  parameter int NUM_SHAPES = 18,
  parameter int COORD_W = 11,
  parameter int COLOUR_W = 3,
  parameter int TIMEOUT_CYC = 65535,
  localparam int ID_W = $clog2(NUM_SHAPES)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           run,
  input  logic                           frame_tick,
  input  logic [NUM_SHAPES-1:0]          shape_mask,
  input  logic                           clear_errs,
  input  logic [NUM_SHAPES-1:0]          draw_done,
  input  logic [NUM_SHAPES*COORD_W-1:0]  load_x,
  input  logic [NUM_SHAPES*COORD_W-1:0]  load_y,
  input  logic [NUM_SHAPES*COLOUR_W-1:0] load_colour,
  output logic [NUM_SHAPES-1:0]          draw_start,
  output logic                           vga_enable,
  output logic [ID_W-1:0]                curr_shape_id,
  output logic [COORD_W-1:0]             out_x,
  output logic [COORD_W-1:0]             out_y,
  output logic [COLOUR_W-1:0]            out_colour,
  output logic                           frame_busy,
  output logic                           overrun,
  output logic                           timeout_err
);
  localparam logic [ID_W-1:0] CLEAR = ID_W'(NUM_SHAPES - 1);
  localparam int CNT_W = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);
  typedef enum logic [2:0] {IDLE, DRAW, NEXT, WAIT_TICK, FINAL_CLEAR, FINAL_WAIT} state_t;
  state_t state, state_n;
  logic [ID_W-1:0] curr, curr_n, nxt_idx;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic vga_n, busy_n, pending, pending_n, to_set, ovr_set, found, drawing, hit_to, done;
  assign drawing = state == DRAW || state == FINAL_CLEAR;
  assign done = draw_done[curr];
  assign hit_to = TIMEOUT_CYC != 0 && cnt == CNT_MAX;
  assign ovr_set = frame_tick && frame_busy;
  assign draw_start = {{(NUM_SHAPES-1){1'b0}}, drawing} << curr;
  assign curr_shape_id = curr;
  assign out_x = load_x[curr*COORD_W +: COORD_W];
  assign out_y = load_y[curr*COORD_W +: COORD_W];
  assign out_colour = load_colour[curr*COLOUR_W +: COLOUR_W];
  // descending scan so the lowest qualifying index is the one left standing
  always_comb begin
    found = 1'b0;
    nxt_idx = '0;
    for (int i = NUM_SHAPES - 2; i >= 0; i--)
      if (shape_mask[i] && (curr == CLEAR || i > int'(curr))) begin
        found = 1'b1;
        nxt_idx = ID_W'(i);
      end
  end
  always_comb begin
    state_n = state;
    curr_n = curr;
    vga_n = vga_enable;
    busy_n = frame_busy;
    pending_n = pending | ovr_set;
    cnt_n = '0;
    to_set = 1'b0;
    case (state)
      IDLE:
        if (run) begin
          vga_n = 1'b1;
          curr_n = CLEAR;
          busy_n = 1'b1;
          state_n = DRAW;
        end
      DRAW, FINAL_CLEAR:
        if (done || hit_to) begin
          to_set = !done;
          state_n = state == DRAW ? NEXT : FINAL_WAIT;
        end else cnt_n = TIMEOUT_CYC != 0 ? cnt + 1'b1 : '0;
      NEXT:
        if (!run) begin
          curr_n = CLEAR;
          state_n = FINAL_CLEAR;
        end else if (found) begin
          curr_n = nxt_idx;
          state_n = DRAW;
        end else begin
          busy_n = 1'b0;
          state_n = WAIT_TICK;
        end
      WAIT_TICK:
        if (!run) begin
          curr_n = CLEAR;
          state_n = FINAL_CLEAR;
        end else if (frame_tick || pending) begin
          pending_n = 1'b0;
          curr_n = CLEAR;
          busy_n = 1'b1;
          state_n = DRAW;
        end
      FINAL_WAIT: begin
        vga_n = 1'b0;
        busy_n = 1'b0;
        pending_n = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      curr <= CLEAR;
      vga_enable <= 1'b0;
      frame_busy <= 1'b0;
      pending <= 1'b0;
      cnt <= '0;
      overrun <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      curr <= curr_n;
      vga_enable <= vga_n;
      frame_busy <= busy_n;
      pending <= pending_n;
      cnt <= cnt_n;
      overrun <= ovr_set ? 1'b1 : clear_errs ? 1'b0 : overrun;
      timeout_err <= to_set ? 1'b1 : clear_errs ? 1'b0 : timeout_err;
    end
endmodule

// File: tb/tb_shape_draw_scheduler.sv
// tb_shape_draw_scheduler: scoreboard bench comparing expected draw_start order against observed channel starts
module tb_shape_draw_scheduler;
  localparam int N = 18;
  localparam int CW = 11;
  localparam int LW = 3;
  localparam int IW = $clog2(N);
  logic clock = 1'b0, reset = 1'b1, run = 1'b0, frame_tick = 1'b0, clear_errs = 1'b0;
  logic [N-1:0] shape_mask = '0, draw_done, draw_start, hang = '0;
  logic [N*CW-1:0] load_x, load_y;
  logic [N*LW-1:0] load_colour;
  logic vga_enable, frame_busy, overrun, timeout_err;
  logic [IW-1:0] curr_shape_id;
  logic [CW-1:0] out_x, out_y;
  logic [LW-1:0] out_colour;
  int n_cmp = 0, n_err = 0, onehot_bad = 0;
  int exp_q[$], obs_q[$];
  int dcnt[N], run_len[N], last_len[N];
  shape_draw_scheduler #(.NUM_SHAPES(N), .COORD_W(CW), .COLOUR_W(LW), .TIMEOUT_CYC(8)) dut (
    .clock(clock), .reset(reset), .run(run), .frame_tick(frame_tick), .shape_mask(shape_mask),
    .clear_errs(clear_errs), .draw_done(draw_done), .load_x(load_x), .load_y(load_y),
    .load_colour(load_colour), .draw_start(draw_start), .vga_enable(vga_enable),
    .curr_shape_id(curr_shape_id), .out_x(out_x), .out_y(out_y), .out_colour(out_colour),
    .frame_busy(frame_busy), .overrun(overrun), .timeout_err(timeout_err));
  always #5 clock = ~clock;
  function automatic int x_of(int i); return i * 3 + 1; endfunction
  function automatic int y_of(int i); return i * 5 + 2; endfunction
  function automatic int c_of(int i); return (i + 1) % 8; endfunction
  // drawer model: done pulses on the fourth cycle of start unless the channel is told to hang
  always_ff @(posedge clock)
    for (int i = 0; i < N; i++) dcnt[i] <= draw_start[i] ? dcnt[i] + 1 : 0;
  always_comb begin
    draw_done = '0;
    for (int i = 0; i < N; i++) draw_done[i] = draw_start[i] && !hang[i] && dcnt[i] == 3;
  end
  initial begin
    logic [N-1:0] prev = '0;
    forever begin
      @(negedge clock);
      if (!$onehot0(draw_start)) onehot_bad++;
      if (draw_start != '0 && draw_start != prev)
        for (int i = 0; i < N; i++) if (draw_start[i]) obs_q.push_back(i);
      for (int i = 0; i < N; i++)
        if (draw_start[i]) run_len[i]++;
        else if (prev[i]) begin
          last_len[i] = run_len[i];
          run_len[i] = 0;
        end
      prev = draw_start;
    end
  end
  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask
  task automatic pulse_tick();
    @(negedge clock) frame_tick = 1'b1;
    @(negedge clock) frame_tick = 1'b0;
  endtask
  task automatic pulse_clear();
    @(negedge clock) clear_errs = 1'b1;
    @(negedge clock) clear_errs = 1'b0;
  endtask
  task automatic wait_busy(input logic v, input int budget);
    int k = 0;
    while (frame_busy !== v && k < budget) begin @(negedge clock); k++; end
    if (frame_busy !== v) begin
      n_cmp++; n_err++;
      $display("FAIL wait_busy: frame_busy=%b required %b within %0d cycles", frame_busy, v, budget);
    end
  endtask
  task automatic wait_start(input int ch, input int budget);
    int k = 0;
    while (draw_start[ch] !== 1'b1 && k < budget) begin @(negedge clock); k++; end
    if (draw_start[ch] !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL wait_start: draw_start[%0d] never rose within %0d cycles", ch, budget);
    end
  endtask
  task automatic test_reset();
    cycles(2);
    n_cmp += 6;
    if (draw_start !== '0) begin n_err++; $display("FAIL rst_draw_start: got %h want 0", draw_start); end
    if (vga_enable !== 1'b0) begin n_err++; $display("FAIL rst_vga_enable: got %b want 0", vga_enable); end
    if (curr_shape_id !== IW'(N-1)) begin n_err++; $display("FAIL rst_curr: got %0d want %0d", curr_shape_id, N-1); end
    if (frame_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", frame_busy); end
    if (overrun !== 1'b0) begin n_err++; $display("FAIL rst_overrun: got %b want 0", overrun); end
    if (timeout_err !== 1'b0) begin n_err++; $display("FAIL rst_timeout: got %b want 0", timeout_err); end
    @(negedge clock) reset = 1'b0;
  endtask
  task automatic test_basic_frame();
    logic [CW-1:0] ex, ey;
    logic [LW-1:0] ec;
    shape_mask = 18'h0_0005;
    exp_q = '{17, 0, 2};
    run = 1'b1;
    wait_busy(1'b1, 10);
    wait_start(2, 40);
    ex = CW'(x_of(2)); ey = CW'(y_of(2)); ec = LW'(c_of(2));
    n_cmp += 4;
    if (curr_shape_id !== IW'(2)) begin n_err++; $display("FAIL mux_id: got %0d want 2", curr_shape_id); end
    if (out_x !== ex) begin n_err++; $display("FAIL mux_x: got %0d want %0d", out_x, ex); end
    if (out_y !== ey) begin n_err++; $display("FAIL mux_y: got %0d want %0d", out_y, ey); end
    if (out_colour !== ec) begin n_err++; $display("FAIL mux_colour: got %0d want %0d", out_colour, ec); end
    wait_busy(1'b0, 40);
    cycles(2);
    n_cmp += 3;
    if (vga_enable !== 1'b1) begin n_err++; $display("FAIL basic_vga: got %b want 1", vga_enable); end
    if (overrun !== 1'b0) begin n_err++; $display("FAIL basic_overrun: got %b want 0", overrun); end
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL basic_count: got %0d starts want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      int e = exp_q.pop_front(), o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL basic_order: got ch %0d want ch %0d", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask
  task automatic test_overrun();
    exp_q = '{17, 0, 2, 17, 0, 2};
    pulse_tick();
    cycles(3);
    pulse_tick();
    cycles(1);
    pulse_tick();
    cycles(60);
    n_cmp += 3;
    if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_flag: got %b want 1", overrun); end
    if (frame_busy !== 1'b0) begin n_err++; $display("FAIL ovr_busy: got %b want 0", frame_busy); end
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL ovr_count: got %0d starts want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      int e = exp_q.pop_front(), o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL ovr_order: got ch %0d want ch %0d", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    pulse_clear();
    n_cmp++;
    if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clear: got %b want 0", overrun); end
    exp_q = '{17, 0, 2, 17, 0, 2};
    pulse_tick();
    cycles(3);
    @(negedge clock) begin frame_tick = 1'b1; clear_errs = 1'b1; end
    @(negedge clock) begin frame_tick = 1'b0; clear_errs = 1'b0; end
    n_cmp++;
    if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_set_wins: got %b want 1", overrun); end
    cycles(60);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL ovr2_count: got %0d starts want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      int e = exp_q.pop_front(), o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL ovr2_order: got ch %0d want ch %0d", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    pulse_clear();
  endtask
  task automatic test_timeout();
    hang[2] = 1'b1;
    shape_mask = 18'h0_000D;
    exp_q = '{17, 0, 2, 3};
    pulse_tick();
    cycles(80);
    n_cmp += 5;
    if (last_len[2] != 8) begin n_err++; $display("FAIL to_len: draw_start[2] high %0d cycles want 8", last_len[2]); end
    if (last_len[3] != 4) begin n_err++; $display("FAIL to_next_len: draw_start[3] high %0d cycles want 4", last_len[3]); end
    if (timeout_err !== 1'b1) begin n_err++; $display("FAIL to_flag: got %b want 1", timeout_err); end
    if (frame_busy !== 1'b0) begin n_err++; $display("FAIL to_busy: got %b want 0", frame_busy); end
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL to_count: got %0d starts want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      int e = exp_q.pop_front(), o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL to_order: got ch %0d want ch %0d", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    hang = '0;
    pulse_clear();
    n_cmp++;
    if (timeout_err !== 1'b0) begin n_err++; $display("FAIL to_clear: got %b want 0", timeout_err); end
  endtask
  task automatic test_stop();
    shape_mask = 18'h0_00A0;
    exp_q = '{17, 5, 17};
    pulse_tick();
    wait_start(5, 40);
    run = 1'b0;
    wait_start(17, 40);
    @(negedge clock) run = 1'b1;
    @(negedge clock) run = 1'b0;
    cycles(40);
    n_cmp += 6;
    if (last_len[5] != 4) begin n_err++; $display("FAIL stop_ch5_len: got %0d want 4", last_len[5]); end
    if (vga_enable !== 1'b0) begin n_err++; $display("FAIL stop_vga: got %b want 0", vga_enable); end
    if (draw_start !== '0) begin n_err++; $display("FAIL stop_start: got %h want 0", draw_start); end
    if (curr_shape_id !== IW'(N-1)) begin n_err++; $display("FAIL stop_curr: got %0d want %0d", curr_shape_id, N-1); end
    if (frame_busy !== 1'b0) begin n_err++; $display("FAIL stop_busy: got %b want 0", frame_busy); end
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL stop_count: got %0d starts want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      int e = exp_q.pop_front(), o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL stop_order: got ch %0d want ch %0d", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask
  task automatic test_empty_mask();
    shape_mask = '0;
    exp_q = '{17, 17};
    run = 1'b1;
    wait_busy(1'b1, 10);
    wait_busy(1'b0, 40);
    pulse_tick();
    wait_busy(1'b0, 40);
    cycles(3);
    n_cmp += 2;
    if (vga_enable !== 1'b1) begin n_err++; $display("FAIL empty_vga: got %b want 1", vga_enable); end
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL empty_count: got %0d starts want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      int e = exp_q.pop_front(), o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL empty_order: got ch %0d want ch %0d", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    exp_q = '{17};
    @(negedge clock) begin frame_tick = 1'b1; run = 1'b0; end
    @(negedge clock) frame_tick = 1'b0;
    cycles(30);
    n_cmp += 3;
    if (vga_enable !== 1'b0) begin n_err++; $display("FAIL tickstop_vga: got %b want 0", vga_enable); end
    if (frame_busy !== 1'b0) begin n_err++; $display("FAIL tickstop_busy: got %b want 0", frame_busy); end
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL tickstop_count: got %0d starts want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      int e = exp_q.pop_front(), o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL tickstop_order: got ch %0d want ch %0d", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask
  task automatic test_reset_mid();
    shape_mask = 18'h0_0005;
    run = 1'b1;
    wait_start(0, 40);
    #1 reset = 1'b1;
    #1;
    n_cmp += 3;
    if (draw_start !== '0) begin n_err++; $display("FAIL rstmid_start: got %h want 0", draw_start); end
    if (vga_enable !== 1'b0) begin n_err++; $display("FAIL rstmid_vga: got %b want 0", vga_enable); end
    if (curr_shape_id !== IW'(N-1)) begin n_err++; $display("FAIL rstmid_curr: got %0d want %0d", curr_shape_id, N-1); end
    run = 1'b0;
    @(negedge clock) reset = 1'b0;
    cycles(10);
    n_cmp++;
    if (draw_start !== '0) begin n_err++; $display("FAIL rstmid_no_clear: got %h want 0", draw_start); end
    exp_q.delete(); obs_q.delete();
  endtask
  task automatic test_onehot();
    n_cmp++;
    if (onehot_bad != 0) begin n_err++; $display("FAIL onehot: %0d cycles with multiple draw_start bits, want 0", onehot_bad); end
  endtask
  initial begin
    for (int i = 0; i < N; i++) begin
      load_x[i*CW +: CW] = CW'(x_of(i));
      load_y[i*CW +: CW] = CW'(y_of(i));
      load_colour[i*LW +: LW] = LW'(c_of(i));
    end
    test_reset();
    test_basic_frame();
    test_overrun();
    test_timeout();
    test_stop();
    test_empty_mask();
    test_reset_mid();
    test_onehot();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
